// File: rtl/turn_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_controller : battleship game-flow sequencer (turns, timer, verdict) |
// | Optional countdown/auto-fire enabled by macro TURN_TIMEOUT_EN.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module turn_controller #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       player_done,
  input  logic       pc_done,
  input  logic [4:0] pc_cells_left,
  input  logic [4:0] player_cells_left,
  output logic       player_en,
  output logic       pc_en,
  output logic       auto_fire,
  output logic [3:0] seconds_left,
  output logic [2:0] state_out,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAYER  = 3'd1,
    S_CHECK_P = 3'd2,
    S_PC      = 3'd3,
    S_CHECK_C = 3'd4,
    S_WIN     = 3'd5,
    S_LOSE    = 3'd6
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_player_en;
  logic   r_pc_en;
  logic   r_win;
  logic   r_lose;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_next = S_PLAYER;
      S_PLAYER:  if (player_done) w_state_next = S_CHECK_P;
      S_CHECK_P: w_state_next = (pc_cells_left == 5'd0) ? S_WIN : S_PC;
      S_PC:      if (pc_done) w_state_next = S_CHECK_C;
      S_CHECK_C: w_state_next = (player_cells_left == 5'd0) ? S_LOSE : S_PLAYER;
      S_WIN:     if (start) w_state_next = S_IDLE;
      S_LOSE:    if (start) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_player_en <= 1'b0;
      r_pc_en     <= 1'b0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_player_en <= (w_state_next == S_PLAYER);
      r_pc_en     <= (w_state_next == S_PC);
      r_win       <= (w_state_next == S_WIN);
      r_lose      <= (w_state_next == S_LOSE);
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int c_CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(CLK_HZ - 1);
  localparam logic [3:0]         c_TURN_SEC = 4'(TURN_SECONDS);

  logic [c_CNT_W-1:0] r_cycle_cnt;
  logic [3:0]         r_seconds;
  logic               r_auto_fire;
  logic               w_turn_entry;
  logic               w_turn_stay;

  assign w_turn_entry = (w_state_next == S_PLAYER) && (r_state != S_PLAYER);
  assign w_turn_stay  = (w_state_next == S_PLAYER) && (r_state == S_PLAYER);

  // A committed shot leaves PLAYER, so a coincident timeout never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_seconds   <= 4'd0;
      r_auto_fire <= 1'b0;
    end else begin
      r_auto_fire <= 1'b0;
      if (w_turn_entry) begin
        r_cycle_cnt <= '0;
        r_seconds   <= c_TURN_SEC;
      end else if (w_turn_stay && (r_seconds != 4'd0)) begin
        if (r_cycle_cnt == c_CNT_MAX) begin
          r_cycle_cnt <= '0;
          r_seconds   <= r_seconds - 4'd1;
          r_auto_fire <= (r_seconds == 4'd1);
        end else begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
      end else if (w_state_next == S_IDLE) begin
        r_cycle_cnt <= '0;
        r_seconds   <= 4'd0;
      end
    end
  end

  assign seconds_left = r_seconds;
  assign auto_fire    = r_auto_fire;
`else
  assign seconds_left = 4'd0;
  assign auto_fire    = 1'b0;
`endif

  assign player_en = r_player_en;
  assign pc_en     = r_pc_en;
  assign win       = r_win;
  assign lose      = r_lose;
  assign state_out = r_state;

endmodule
`default_nettype wire
